uart_rx_framer: RTL and testbench

//  Receive-side counterpart of the UART transmit path: deserialises one async frame from serial_i.

---
 rtl/uart_rx_framer_pkg.sv | 30 +++
 rtl/uart_rx_framer_bit_sampler.sv | 59 +++++
 rtl/uart_rx_framer.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_framer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : uart_rx_framer_pkg
//  Description : Shared constants for the UART receive framer: FSM state
//                encodings, the divider floor and the parity helper that the
//                transmit path also uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_framer_pkg;

   // Smallest usable clocks-per-bit; the 3-point vote needs H-1 >= 1.
   localparam int MIN_DIVIDER_DEFAULT = 4;

   // Receiver FSM encodings
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   // Parity bit a transmitter would append: even -> XOR of data, odd -> inverted.
   function automatic logic calc_parity(input logic [7:0] data, input logic even);
      return (^data) ^ ~even;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_framer_bit_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_framer_bit_sampler
//  Description : Two-flop synchroniser for the async serial line, falling-edge
//                detect on the synchronised line, and a 3-point majority vote
//                around the bit centre (counts H-1, H, H+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framer_bit_sampler (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       serial_i,
   input  logic [7:0] count_i,
   input  logic [7:0] half_i,
   output logic       sync_o,
   output logic       fall_o,
   output logic       bit_o,
   output logic       bit_strobe_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic samp0_q;
   logic samp1_q;

   // Synchroniser and edge-history flops; preset high so reset never looks like a start edge
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= serial_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Capture the first two vote samples; the third is the live line at H+1
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         samp0_q <= 1'b1;
         samp1_q <= 1'b1;
      end else begin
         if (count_i == (half_i - 8'd1)) samp0_q <= sync_q;
         if (count_i == half_i)          samp1_q <= sync_q;
      end
   end

   assign sync_o       = sync_q;
   assign fall_o       = prev_q & ~sync_q;
   assign bit_strobe_o = (count_i == (half_i + 8'd1));
   assign bit_o        = (samp0_q & samp1_q) | (samp0_q & sync_q) | (samp1_q & sync_q);

endmodule

`default_nettype wire

// File: rtl/uart_rx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_framer
//  Description : UART receiver. Deserialises start + 8 data bits (LSB first)
//                + optional parity + 1/2 stop bits and presents each byte with
//                parity/framing/overrun flags over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framer
   import uart_rx_framer_pkg::*;
#(
   parameter int MIN_DIVIDER = MIN_DIVIDER_DEFAULT
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       serial_i,
   input  logic [7:0] clock_divider_i,
   input  logic       parity_bit_i,
   input  logic       parity_even_i,
   input  logic       two_stop_bits_i,
   input  logic       ready_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       parity_error_o,
   output logic       framing_error_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam logic [7:0] MIN_DIV8 = 8'(MIN_DIVIDER);

   // FSM
   logic [2:0] state_q;
   logic [2:0] state_d;

   // Frame configuration captured at start detect
   logic [7:0] div_q;
   logic       par_en_q;
   logic       par_even_q;
   logic       two_stop_q;

   // Bit timer and receive datapath
   logic [7:0] count_q;
   logic [7:0] count_d;
   logic [2:0] bit_idx_q;
   logic [7:0] shift_q;
   logic       par_err_q;
   logic       stop1_q;
   logic       wait_high_q;

   // Presented byte and flags
   logic [7:0] data_q;
   logic       valid_q;
   logic       perr_q;
   logic       ferr_q;
   logic       ovr_q;

   // Combinational helpers
   logic [7:0] div_floor;
   logic [7:0] half;
   logic       bit_end;
   logic       start_go;
   logic       accept;
   logic       line_sync;
   logic       line_fall;
   logic       bit_val;
   logic       bit_strobe;
   logic       deliver;
   logic       shift_en;
   logic       par_sample;
   logic       stop1_sample;
   logic       ferr_new;

   assign div_floor = (clock_divider_i < MIN_DIV8) ? MIN_DIV8 : clock_divider_i;
   assign half      = div_q >> 1;
   assign bit_end   = (count_q == (div_q - 8'd1));
   assign start_go  = (state_q == ST_IDLE) & line_fall & ~wait_high_q;
   assign accept    = valid_q & ready_i;

   uart_rx_framer_bit_sampler u_sampler (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .serial_i     (serial_i),
      .count_i      (count_q),
      .half_i       (half),
      .sync_o       (line_sync),
      .fall_o       (line_fall),
      .bit_o        (bit_val),
      .bit_strobe_o (bit_strobe)
   );

   // State register
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; STOP1 without a second stop bit leaves at the sample point to allow resync
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_go) state_d = ST_START;
         end
         ST_START: begin
            if (bit_strobe && bit_val) state_d = ST_IDLE;
            else if (bit_end)          state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && (bit_idx_q == 3'd7)) state_d = par_en_q ? ST_PARITY : ST_STOP1;
         end
         ST_PARITY: begin
            if (bit_end) state_d = ST_STOP1;
         end
         ST_STOP1: begin
            if (two_stop_q) begin
               if (bit_end) state_d = ST_STOP2;
            end else if (bit_strobe) begin
               state_d = ST_IDLE;
            end
         end
         ST_STOP2: begin
            if (bit_strobe) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: per-state sample enables, delivery strobe and busy
   always_comb begin
      busy_o       = (state_q != ST_IDLE);
      shift_en     = (state_q == ST_DATA)   & bit_strobe;
      par_sample   = (state_q == ST_PARITY) & bit_strobe;
      stop1_sample = (state_q == ST_STOP1)  & bit_strobe;
      deliver      = bit_strobe & (((state_q == ST_STOP1) & ~two_stop_q) | (state_q == ST_STOP2));
      ferr_new     = (state_q == ST_STOP2) ? (~stop1_q | ~bit_val) : ~bit_val;
      if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || bit_end) count_d = 8'd0;
      else                                                         count_d = count_q + 8'd1;
   end

   // Bit timer, config latch, shift register and pending frame flags
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         count_q     <= 8'd0;
         div_q       <= 8'd0;
         par_en_q    <= 1'b0;
         par_even_q  <= 1'b0;
         two_stop_q  <= 1'b0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'd0;
         par_err_q   <= 1'b0;
         stop1_q     <= 1'b1;
         wait_high_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (start_go) begin
            div_q      <= div_floor;
            par_en_q   <= parity_bit_i;
            par_even_q <= parity_even_i;
            two_stop_q <= two_stop_bits_i;
            bit_idx_q  <= 3'd0;
            par_err_q  <= 1'b0;
         end else if ((state_q == ST_DATA) && bit_end) begin
            bit_idx_q <= bit_idx_q + 3'd1;
         end
         if (shift_en)     shift_q   <= {bit_val, shift_q[7:1]};
         if (par_sample)   par_err_q <= (calc_parity(shift_q, par_even_q) != bit_val);
         if (stop1_sample) stop1_q   <= bit_val;
         // A low stop bit means the line may still be low: block start detect until it idles high
         if (deliver && ferr_new)                  wait_high_q <= 1'b1;
         else if ((state_q == ST_IDLE) && line_sync) wait_high_q <= 1'b0;
      end
   end

   // Output register: deliver wins over accept; delivering onto an unaccepted byte flags overrun
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (deliver) begin
         data_q  <= shift_q;
         perr_q  <= par_err_q & par_en_q;
         ferr_q  <= ferr_new;
         valid_q <= 1'b1;
         ovr_q   <= valid_q & ~ready_i;
      end else if (accept) begin
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

   assign data_o          = data_q;
   assign valid_o         = valid_q;
   assign parity_error_o  = perr_q;
   assign framing_error_o = ferr_q;
   assign overrun_o       = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_framer
//  Description : Scoreboard bench for uart_rx_framer. Stimulus serialises
//                frames and queues the expected byte/flags; a monitor pops and
//                compares on every accepted byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framer;

   logic       clock_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       serial_i = 1'b1;
   logic [7:0] clock_divider_i = 8'd16;
   logic       parity_bit_i = 1'b0;
   logic       parity_even_i = 1'b0;
   logic       two_stop_bits_i = 1'b0;
   logic       ready_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o;
   logic       parity_error_o;
   logic       framing_error_o;
   logic       overrun_o;
   logic       busy_o;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       ovr;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   uart_rx_framer #(.MIN_DIVIDER(4)) dut (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .serial_i        (serial_i),
      .clock_divider_i (clock_divider_i),
      .parity_bit_i    (parity_bit_i),
      .parity_even_i   (parity_even_i),
      .two_stop_bits_i (two_stop_bits_i),
      .ready_i         (ready_i),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .parity_error_o  (parity_error_o),
      .framing_error_o (framing_error_o),
      .overrun_o       (overrun_o),
      .busy_o          (busy_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      serial_i = 1'b1;
      repeat (n) @(negedge clock_i);
   endtask

   task automatic drive_bit(input logic v, input int cycles);
      serial_i = v;
      repeat (cycles) @(negedge clock_i);
   endtask

   // Serialise one frame and queue what the host should see for it.
   task automatic send_frame(input logic [7:0] d, input int div, input bit pen, input bit peven,
                             input bit two, input bit pbit, input bit s1, input bit s2,
                             input bit leave_low, input bit scramble);
      int   eff;
      int   ones;
      exp_t e;
      eff  = (div < 4) ? 4 : div;
      ones = $countones(d) + (pen ? int'(pbit) : 0);
      clock_divider_i = 8'(div);
      parity_bit_i    = pen;
      parity_even_i   = peven;
      two_stop_bits_i = two;
      e.data = d;
      e.perr = pen && ((ones % 2) != (peven ? 0 : 1));
      e.ferr = !s1 || (two && !s2);
      e.ovr  = 1'b0;
      // A byte still waiting with ready low gets replaced and marked overrun
      if (!ready_i && exp_q.size() > 0) begin
         e.ovr = 1'b1;
         exp_q[exp_q.size()-1] = e;
      end else begin
         exp_q.push_back(e);
      end
      drive_bit(1'b0, eff);
      if (scramble) begin
         clock_divider_i = 8'($urandom);
         parity_bit_i    = 1'($urandom);
         parity_even_i   = 1'($urandom);
         two_stop_bits_i = 1'($urandom);
      end
      for (int i = 0; i < 8; i++) drive_bit(d[i], eff);
      if (pen) drive_bit(pbit, eff);
      drive_bit(s1, eff);
      if (two) drive_bit(s2, eff);
      if (!leave_low) serial_i = 1'b1;
   endtask

   // Monitor: compare each accepted byte against the head of the queue
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock_i);
         #1;
         if (reset_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_byte: got data 0x%0h with nothing queued, required no valid", data_o);
            end else begin
               e = exp_q.pop_front();
               check("data",    32'(data_o),          32'(e.data));
               check("perr",    32'(parity_error_o),  32'(e.perr));
               check("ferr",    32'(framing_error_o), 32'(e.ferr));
               check("overrun", 32'(overrun_o),       32'(e.ovr));
            end
            @(negedge clock_i);
            #1;
            check("valid_drop",  32'(valid_o),   32'd0);
            check("ovr_cleared", 32'(overrun_o), 32'd0);
         end
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, %0d frames pending, required 0", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bit seen;
      int t;
      // Reset state
      repeat (3) @(negedge clock_i);
      #1;
      check("rst_data",  32'(data_o),          32'h00);
      check("rst_valid", 32'(valid_o),         32'd0);
      check("rst_perr",  32'(parity_error_o),  32'd0);
      check("rst_ferr",  32'(framing_error_o), 32'd0);
      check("rst_ovr",   32'(overrun_o),       32'd0);
      check("rst_busy",  32'(busy_o),          32'd0);
      @(negedge clock_i);
      reset_i = 1'b1;
      idle(10);

      // 8N1 0xA5, 8E1 with wrong and right parity bit
      send_frame(8'hA5, 16, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(20);
      send_frame(8'h03, 16, 1, 1, 0, 1, 1, 1, 0, 0);
      idle(20);
      send_frame(8'h03, 16, 1, 1, 0, 0, 1, 1, 0, 0);
      idle(20);

      // 8N2 with low second stop bit, line then held low: no frame may start
      send_frame(8'hC3, 16, 0, 0, 1, 0, 1, 0, 1, 0);
      repeat (8) @(negedge clock_i);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock_i);
         seen |= busy_o;
      end
      check("held_low_busy", 32'(seen), 32'd0);
      idle(10);
      send_frame(8'h3C, 16, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(20);

      // Glitch: 3-clock low pulse is a false start
      serial_i = 1'b0;
      repeat (3) @(negedge clock_i);
      serial_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock_i);
         seen |= busy_o;
      end
      check("glitch_busy_pulse", 32'(seen), 32'd1);
      repeat (30) @(negedge clock_i);
      check("glitch_idle", 32'(busy_o), 32'd0);

      // Overrun: two frames with ready low, then accept
      ready_i = 1'b0;
      send_frame(8'h11, 16, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(40);
      send_frame(8'h22, 16, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(40);
      check("ovr_valid", 32'(valid_o),   32'd1);
      check("ovr_data",  32'(data_o),    32'h22);
      check("ovr_flag",  32'(overrun_o), 32'd1);
      ready_i = 1'b1;
      idle(10);

      // Reset in the middle of the data bits, then a clean 0x5A
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b0, 8);
      reset_i = 1'b0;
      #1;
      check("midrst_valid", 32'(valid_o), 32'd0);
      check("midrst_busy",  32'(busy_o),  32'd0);
      check("midrst_data",  32'(data_o),  32'h00);
      repeat (4) @(negedge clock_i);
      serial_i = 1'b1;
      repeat (2) @(negedge clock_i);
      reset_i = 1'b1;
      idle(20);
      send_frame(8'h5A, 16, 0, 0, 0, 0, 1, 1, 0, 0);
      idle(20);

      // Randomised frames: divider including sub-floor values, mid-frame config scrambling
      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         int  div;
         bit  pen, peven, two, pbit, s1, s2;
         d     = 8'($urandom);
         div   = int'($urandom_range(0, 24));
         pen   = 1'($urandom);
         peven = 1'($urandom);
         two   = 1'($urandom);
         pbit  = 1'($countones(d) % 2);
         if (!peven) pbit = ~pbit;
         if ($urandom_range(0, 3) == 0) pbit = ~pbit;
         s1    = ($urandom_range(0, 7) != 0);
         s2    = ($urandom_range(0, 7) != 0);
         send_frame(d, div, pen, peven, two, pbit, s1, s2, 0, 1);
         idle(int'($urandom_range(4, 12)));
      end

      // Drain
      t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(negedge clock_i);
         t++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
